// File: rtl/haraka_pkg.sv
// haraka_pkg: shared widths, padding bytes and FSM encoding for the Haraka-S sponge controller
package haraka_pkg;
    localparam int RATE_BITS = 256;
    localparam int STATE_BITS = 512;
    localparam logic [7:0] PAD_START = 8'h1F;
    localparam logic [7:0] PAD_END = 8'h80;
    typedef enum logic [1:0] {ABSORB, PERM, PAD, OUT} st_t;
endpackage

// File: rtl/haraka_s_sponge_ctrl_if.sv
// haraka_s_sponge_ctrl_if: message-in and digest-out valid/ready streams of the sponge controller
interface haraka_s_sponge_ctrl_if;
    import haraka_pkg::*;
    logic msg_valid;
    logic msg_ready;
    logic [RATE_BITS-1:0] msg_data;
    logic msg_last;
    logic [5:0] msg_bytes;
    logic digest_valid;
    logic digest_ready;
    logic [RATE_BITS-1:0] digest_data;
    modport master(output msg_valid, msg_data, msg_last, msg_bytes, digest_ready,
                   input msg_ready, digest_valid, digest_data);
    modport slave(input msg_valid, msg_data, msg_last, msg_bytes, digest_ready,
                  output msg_ready, digest_valid, digest_data);
endinterface

// File: rtl/haraka_pad.sv
// haraka_pad: Haraka-S padding of a final message block; flags when a full block needs a separate pad block
module haraka_pad
    import haraka_pkg::*;
(
    input  logic [RATE_BITS-1:0] data,
    input  logic [5:0]           bytes,
    input  logic                 last,
    output logic [RATE_BITS-1:0] padded,
    output logic                 need_extra
);
    logic full;
    // bytes[5] set means a full (>= 32 byte) block, so no room for padding
    assign full = !last || bytes[5];
    assign need_extra = last && bytes[5];
    for (genvar i = 0; i < 32; i++) begin : g_byte
        localparam logic [5:0] J = 6'(i);
        assign padded[RATE_BITS-1-8*i -: 8] = full ? data[RATE_BITS-1-8*i -: 8] :
            ((J < bytes ? data[RATE_BITS-1-8*i -: 8] : 8'h00) ^
             (J == bytes ? PAD_START : 8'h00) ^
             (i == 31 ? PAD_END : 8'h00));
    end
endmodule

// File: rtl/haraka_s_sponge_ctrl.sv
// haraka_s_sponge_ctrl: owns the 512-bit sponge state, absorbs padded blocks, sequences core passes and squeezes digests
module haraka_s_sponge_ctrl
    import haraka_pkg::*;
#(
    parameter int NUM_ROUNDS = 5,
    parameter int ROUND_LAT  = 2,
    parameter int OUT_BLOCKS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    haraka_s_sponge_ctrl_if.slave bus,
    output logic [STATE_BITS-1:0] core_in,
    output logic                  core_sel,
    input  logic [STATE_BITS-1:0] core_out
);
    localparam int RW = NUM_ROUNDS > 1 ? $clog2(NUM_ROUNDS) : 1;
    localparam int LW = ROUND_LAT > 1 ? $clog2(ROUND_LAT) : 1;
    localparam int BW = $clog2(OUT_BLOCKS + 1);
    localparam logic [RW-1:0] LAST_RND = RW'(NUM_ROUNDS - 1);
    localparam logic [LW-1:0] LAST_LAT = LW'(ROUND_LAT - 1);

    st_t st, st_nxt;
    logic [STATE_BITS-1:0] state, state_nxt;
    logic [RW-1:0] round, round_nxt;
    logic [LW-1:0] lat, lat_nxt;
    logic pad_pending, pend_nxt;
    logic last_seen, last_nxt;
    logic [BW-1:0] blocks_left, left_nxt;
    logic dvalid, dv_nxt;
    logic [RATE_BITS-1:0] ddata, dd_nxt;
    logic [RATE_BITS-1:0] padded;
    logic need_extra;

    haraka_pad u_pad (
        .data      (bus.msg_data),
        .bytes     (bus.msg_bytes),
        .last      (bus.msg_last),
        .padded    (padded),
        .need_extra(need_extra)
    );

    assign bus.msg_ready = st == ABSORB;
    assign bus.digest_valid = dvalid;
    assign bus.digest_data = ddata;
    assign core_in = state;
    assign core_sel = 1'b0;

    always_comb begin
        st_nxt = st;
        state_nxt = state;
        round_nxt = round;
        lat_nxt = lat;
        pend_nxt = pad_pending;
        last_nxt = last_seen;
        left_nxt = blocks_left;
        dv_nxt = dvalid;
        dd_nxt = ddata;
        case (st)
            ABSORB: if (bus.msg_valid) begin
                state_nxt[STATE_BITS-1 -: RATE_BITS] = state[STATE_BITS-1 -: RATE_BITS] ^ padded;
                pend_nxt = need_extra;
                last_nxt = bus.msg_last;
                round_nxt = '0;
                lat_nxt = '0;
                st_nxt = PERM;
            end
            PERM: begin
                lat_nxt = lat + 1'b1;
                if (lat == LAST_LAT) begin
                    lat_nxt = '0;
                    round_nxt = round + 1'b1;
                    state_nxt = core_out;
                    if (round == LAST_RND) begin
                        round_nxt = '0;
                        if (pad_pending) st_nxt = PAD;
                        else if (last_seen) begin
                            // the digest is registered from the freshly captured state
                            st_nxt = OUT;
                            dv_nxt = 1'b1;
                            dd_nxt = core_out[STATE_BITS-1 -: RATE_BITS];
                            if (blocks_left == '0) left_nxt = BW'(OUT_BLOCKS);
                        end else st_nxt = ABSORB;
                    end
                end
            end
            PAD: begin
                state_nxt[STATE_BITS-1 -: 8] = state[STATE_BITS-1 -: 8] ^ PAD_START;
                state_nxt[RATE_BITS+7 -: 8] = state[RATE_BITS+7 -: 8] ^ PAD_END;
                pend_nxt = 1'b0;
                st_nxt = PERM;
            end
            OUT: if (bus.digest_ready) begin
                dv_nxt = 1'b0;
                if (blocks_left > BW'(1)) begin
                    left_nxt = blocks_left - 1'b1;
                    st_nxt = PERM;
                end else begin
                    state_nxt = '0;
                    last_nxt = 1'b0;
                    left_nxt = '0;
                    st_nxt = ABSORB;
                end
            end
            default: st_nxt = ABSORB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= ABSORB;
            state <= '0;
            round <= '0;
            lat <= '0;
            pad_pending <= 1'b0;
            last_seen <= 1'b0;
            blocks_left <= '0;
            dvalid <= 1'b0;
            ddata <= '0;
        end else begin
            st <= st_nxt;
            state <= state_nxt;
            round <= round_nxt;
            lat <= lat_nxt;
            pad_pending <= pend_nxt;
            last_seen <= last_nxt;
            blocks_left <= left_nxt;
            dvalid <= dv_nxt;
            ddata <= dd_nxt;
        end
    end
endmodule
